regfile_debug_master: RTL and testbench
=======================================

# regfile_debug_master

Debug/bring-up initiator that drives the spare read port and the write port of the 32×32 register file (`regfile`) to dump or preload a contiguous, wrapping range of registers. It uses two ready/valid streams: a dump stream out and a load stream in. Before touching the register file it requests a CPU hold and waits for the core to report idle. It sits beside the MIPS datapath; the top level muxes its `ra`/`wa`/`wd`/`we` into the register file while `busy` is high.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width (32 registers)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  command strobe, sampled only in IDLE
- `mode`  in  1  0 = dump, 1 = load; latched with `start`
- `first_addr`  in  ADDR_W  first register index; latched with `start`
- `last_addr`  in  ADDR_W  last register index, inclusive; latched with `start`
- `cpu_idle`  in  1  core is stalled and not writing the register file
- `busy`  out  1  command in progress; also the CPU hold request
- `done`  out  1  one-cycle completion pulse
- `ra`  out  ADDR_W  register file read address
- `rd`  in  DATA_W  register file read data (combinational)
- `wa`  out  ADDR_W  register file write address
- `wd`  out  DATA_W  register file write data
- `we`  out  1  register file write enable
- `dump_valid` / `dump_ready`  out/in  1  dump stream handshake
- `dump_addr`  out  ADDR_W  index of the current dump word
- `dump_data`  out  DATA_W  registered dump word
- `load_valid` / `load_ready`  in/out  1  load stream handshake
- `load_data`  in  DATA_W  word to write
- `checksum`  out  DATA_W  present only with `REGDBG_CHECKSUM_EN`

## Operation
- **FSM states:** IDLE, WAIT_IDLE, DUMP_RD, DUMP_TX, LOAD, DONE.
- **IDLE:**
  - `start`=1 latches `mode`, `first_addr` and `last_addr`.
  - The address counter is loaded with `first_addr`.
  - Next state is WAIT_IDLE.
- **WAIT_IDLE:** `busy`=1. When `cpu_idle`=1, go to DUMP_RD (mode 0) or LOAD (mode 1). There is no timeout.
- **DUMP_RD:**
  - `ra` = counter.
  - `rd` is registered into `dump_data` and the counter into `dump_addr`.
  - Next state is DUMP_TX.
- **DUMP_TX:**
  - `dump_valid`=1. `dump_data` and `dump_addr` stay stable while `dump_ready`=0.
  - On handshake: if counter == last → DONE; else counter+1 (mod 32) → DUMP_RD.
- **LOAD:**
  - `load_ready`=1.
  - `we` = `load_valid` && counter≠0 (combinational). `wa` = counter, `wd` = `load_data`.
  - On handshake: if counter == last → DONE; else counter+1 (mod 32).
  - A word aimed at address 0 is consumed but not written.
- **DONE:** `done`=1 and `busy`=1 for one cycle, then IDLE.
- **Wrap-around:** if `first_addr` > `last_addr`, the sequence wraps through 31 to 0. Example: 30→1 transfers 30, 31, 0, 1.
- **Single word:** `first_addr` == `last_addr` transfers exactly one word.
- **`start` while busy:** ignored; no queueing.
- **Outside their states:** `we`, `dump_valid` and `load_ready` are 0.
- **Reset mid-operation:**
  - FSM returns to IDLE immediately. Any write in flight is dropped; the register file is reset by the same signal.

## Timing
- **Reset values:** all outputs are 0, including `ra`, `wa`, `wd`, `dump_addr`, `dump_data`, `done`, `busy` and `checksum`.
- **`busy`:** rises the cycle after `start` is sampled and falls the cycle after `done`.
- **Dump latency:** with `cpu_idle` held at 1, `dump_valid` first asserts in cycle 3, where cycle 0 is the `start` cycle. Throughput is one word per 2 cycles when `dump_ready` is held at 1.
- **Load latency:** `load_ready` first asserts in cycle 2. Throughput is one word per cycle. Each write lands at the clock edge ending its handshake cycle.
- **`done` after final handshake:** high in the cycle after the last handshake.
- **Command duration:**
  - Dump of N words with no stalls: 2N+2 cycles from `start` to `done`.
  - Load of N words with no stalls: N+2 cycles.

## Configuration
- Macro: `REGDBG_CHECKSUM_EN`.
- **Defined:**
  - `checksum` port present.
  - Value is the XOR of every word handshaked in the current command (`dump_data` or `load_data`), including load words aimed at address 0.
  - Cleared when `start` is accepted; held after `done` until the next accepted `start`.
- **Undefined:** no port and no accumulator register; all other behaviour is identical.

## Structure
- Shared package `regdbg_pkg` holds:
  - the state enum `regdbg_state_t`;
  - `MODE_DUMP`/`MODE_LOAD` constants;
  - `REG_COUNT` = 32.
- No sub-module: FSM, wrapping address counter and data registers stay flat in one module. The top-level port mux into `regfile` lives outside this block.

## Test plan
- **Full dump:**
  - Preload r1..r31 = 0x100+i; dump 0→31 with `dump_ready`=1.
  - Expect 32 words: r0=0, r5=0x105, r31=0x11F; `done` at cycle 66.
- **Backpressure:**
  - Dump 3→3; hold `dump_ready`=0 for 5 cycles.
  - Expect `dump_data`/`dump_addr` stable, exactly one handshake, one `done`.
- **Load with zero protection:**
  - Load 31→1 (wrap) with words 0xA, 0xB, 0xC.
  - Expect r31=0xA, r0 reads 0, r1=0xC; `we` never high with `wa`=0.
- **Hold handshake:**
  - `cpu_idle`=0 for 10 cycles after `start`.
  - Expect `busy`=1, no `we`, no `dump_valid` until `cpu_idle` rises.
- **Reset mid-operation:**
  - Assert `reset` during load word 2 of 4.
  - Expect IDLE next, all outputs 0; a new `start` works normally.
- **Checksum (macro defined):**
  - Dump r1=0xF0F0, r2=0x0FF0.
  - Expect `checksum`=0xFF00.

Source files
------------

// File: rtl/regdbg_pkg.sv
// Shared types and constants for the register-file debug master.
package regdbg_pkg;

    localparam int REG_COUNT = 32;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        DUMP_RD,
        DUMP_TX,
        LOAD,
        DONE
    } regdbg_state_t;

endpackage

// File: rtl/regfile_debug_master.sv
// Debug initiator that dumps/preloads a wrapping register range; REGDBG_CHECKSUM_EN adds an XOR checksum port.
// Latency: dump_valid in cycle 3 after start (1 word / 2 cycles), load_ready in cycle 2 (1 word / cycle).
// Backpressure: dump word held stable while dump_ready=0; load stalls while load_valid=0; waits on cpu_idle forever.
module regfile_debug_master
    import regdbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              cpu_idle,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              we,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data
`ifdef REGDBG_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    regdbg_state_t     state;
    logic              mode_q;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] last_q;
    logic              at_last;
    logic              dump_hs;
    logic              load_hs;

    assign at_last    = (cnt == last_q);
    assign dump_hs    = (state == DUMP_TX) && dump_ready;
    assign load_hs    = (state == LOAD) && load_valid;

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign dump_valid = (state == DUMP_TX);
    assign load_ready = (state == LOAD);
    assign ra         = (state == DUMP_RD) ? cnt : '0;
    assign wa         = load_ready ? cnt : '0;
    assign wd         = load_ready ? load_data : '0;
    // r0 is hardwired zero in the core, so words aimed at it are consumed silently
    assign we         = load_hs && (cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= MODE_DUMP;
            cnt       <= '0;
            last_q    <= '0;
            dump_addr <= '0;
            dump_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        cnt    <= first_addr;
                        last_q <= last_addr;
                        state  <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (cpu_idle) state <= (mode_q == MODE_LOAD) ? LOAD : DUMP_RD;
                end
                DUMP_RD: begin
                    dump_data <= rd;
                    dump_addr <= cnt;
                    state     <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (dump_ready) begin
                        if (at_last) begin
                            state <= DONE;
                        end else begin
                            cnt   <= cnt + ADDR_W'(1);
                            state <= DUMP_RD;
                        end
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        if (at_last) state <= DONE;
                        else         cnt   <= cnt + ADDR_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REGDBG_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if ((state == IDLE) && start) begin
            csum <= '0;
        end else if (dump_hs) begin
            csum <= csum ^ dump_data;
        end else if (load_hs) begin
            csum <= csum ^ load_data;
        end
    end

    assign checksum = csum;
`endif

endmodule

// File: tb/tb_regfile_debug_master.sv
// Randomized bench for regfile_debug_master against an array model of the register file contents.
module tb_regfile_debug_master;
    import regdbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic        cpu_idle = 1'b0;
    logic        busy, done, we, dump_valid, load_ready;
    logic [4:0]  ra, wa, dump_addr;
    logic [31:0] rd, wd, dump_data;
    logic        dump_ready = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
`ifdef REGDBG_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    regfile_debug_master #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .first_addr(first_addr), .last_addr(last_addr), .cpu_idle(cpu_idle),
        .busy(busy), .done(done), .ra(ra), .rd(rd), .wa(wa), .wd(wd), .we(we),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data)
`ifdef REGDBG_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    // Register file the block drives; r0 never written so it reads 0.
    logic [31:0] rf [32];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end
    assign rd = rf[ra];

    int zero_wr = 0;
    always @(negedge clk) if (we && wa == 5'd0) zero_wr++;

    logic [31:0] mdl [32];
    logic [31:0] ldq [$];
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ra"}, 32'(ra), 32'd0);
        check({tag, "_wa"}, 32'(wa), 32'd0);
        check({tag, "_wd"}, wd, 32'd0);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_dvalid"}, 32'(dump_valid), 32'd0);
        check({tag, "_daddr"}, 32'(dump_addr), 32'd0);
        check({tag, "_ddata"}, dump_data, 32'd0);
        check({tag, "_lready"}, 32'(load_ready), 32'd0);
`ifdef REGDBG_CHECKSUM_EN
        check({tag, "_csum"}, checksum, 32'd0);
`endif
    endtask

    task automatic compare_rf(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), rf[i], mdl[i]);
    endtask

    // One command: hold = cycles cpu_idle stays low after start, stall_pct = random
    // ready/valid drop rate, rdy_after = first cycle ready/valid may go high,
    // abort_word = load word index during which reset is pulsed (-1 = none).
    task automatic run_cmd(input logic m, input logic [4:0] f, input logic [4:0] l,
                           input int hold, input int stall_pct, input int rdy_after,
                           input int abort_word);
        int n, idx, first_act, done_cnt, done_cyc, bad, cyc;
        logic [4:0]  a, pa;
        logic [31:0] xr, pd;
        logic        was_stall, aborted, timed;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        idx = 0; first_act = -1; done_cnt = 0; done_cyc = -1; bad = 0;
        xr = '0; pd = '0; pa = '0; was_stall = 0; aborted = 0;
        timed = (stall_pct == 0) && (rdy_after == 0);
        start = 1'b1; mode = m; first_addr = f; last_addr = l;
        for (cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
            if (cyc > 0) start = 1'b0;
            cpu_idle   = (cyc > hold);
            dump_ready = (cyc >= rdy_after) && ($urandom_range(99) >= stall_pct);
            load_valid = (cyc >= rdy_after) && ($urandom_range(99) >= stall_pct);
            load_data  = (idx < ldq.size()) ? ldq[idx] : $urandom;
            @(negedge clk);
            if (cyc == 0) check("busy_at_start", 32'(busy), 32'd0);
            if (cyc >= 1 && cyc <= hold && (!busy || we || dump_valid || load_ready)) bad++;
            if (load_ready && !load_valid && we) bad++;
            if ((dump_valid || load_ready) && first_act < 0) first_act = cyc;
            if (dump_valid) begin
                if (was_stall) begin
                    check("stall_data", dump_data, pd);
                    check("stall_addr", 32'(dump_addr), 32'(pa));
                end
                if (dump_ready) begin
                    a = f + 5'(idx);
                    check("dump_addr", 32'(dump_addr), 32'(a));
                    check("dump_data", dump_data, mdl[a]);
                    xr ^= mdl[a];
                    idx++;
                    was_stall = 0;
                end else begin
                    was_stall = 1; pd = dump_data; pa = dump_addr;
                end
            end
            if (load_ready && load_valid) begin
                a = f + 5'(idx);
                if (idx == abort_word) begin
                    reset = 1'b1;
                    #1;
                    check_quiet("rst_mid");
                    for (int i = 0; i < 32; i++) mdl[i] = '0;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    aborted = 1;
                    break;
                end
                check("wa", 32'(wa), 32'(a));
                check("we", 32'(we), 32'(a != 5'd0));
                check("wd", wd, load_data);
                if (a != 5'd0) mdl[a] = load_data;
                xr ^= load_data;
                idx++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            @(posedge clk); #1;
        end
        start = 1'b0; dump_ready = 1'b0; load_valid = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check_quiet("after_rst");
            @(posedge clk); #1;
        end else begin
            check("words", 32'(idx), 32'(n));
            check("done_seen", 32'(done_cnt), 32'd1);
            check("hold_or_we", 32'(bad), 32'd0);
            if (timed) begin
                check("first_act", 32'(first_act), 32'((m == MODE_LOAD) ? 2 + hold : 3 + hold));
                check("done_cyc", 32'(done_cyc), 32'((m == MODE_LOAD) ? n + 2 + hold : 2 * n + 2 + hold));
            end
            @(negedge clk);
            check("busy_after", 32'(busy), 32'd0);
            check("done_after", 32'(done), 32'd0);
`ifdef REGDBG_CHECKSUM_EN
            check("checksum", checksum, xr);
`endif
            @(posedge clk); #1;
        end
        compare_rf(aborted ? "rf_rst" : "rf");
        ldq.delete();
    endtask

    initial begin
        logic       m;
        logic [4:0] f, l;
        int         sp;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Preload r1..r31 = 0x100+i, then dump the whole file.
        for (int i = 1; i < 32; i++) ldq.push_back(32'h100 + 32'(i));
        run_cmd(MODE_LOAD, 5'd1, 5'd31, 0, 0, 0, -1);
        run_cmd(MODE_DUMP, 5'd0, 5'd31, 0, 0, 0, -1);
        check("r5", rf[5], 32'h105);
        check("r31", rf[31], 32'h11F);

        // Single word under 5 cycles of backpressure.
        run_cmd(MODE_DUMP, 5'd3, 5'd3, 0, 0, 8, -1);

        // Wrapping load through r0.
        ldq = '{32'hA, 32'hB, 32'hC};
        run_cmd(MODE_LOAD, 5'd31, 5'd1, 0, 0, 0, -1);
        check("wrap_r31", rf[31], 32'hA);
        check("wrap_r0", rf[0], 32'h0);
        check("wrap_r1", rf[1], 32'hC);

        // CPU hold for 10 cycles.
        run_cmd(MODE_DUMP, 5'd30, 5'd2, 10, 0, 0, -1);

        // Reset during word 2 of 4, then a normal command.
        run_cmd(MODE_LOAD, 5'd4, 5'd7, 0, 0, 0, 1);
        run_cmd(MODE_LOAD, 5'd8, 5'd10, 0, 0, 0, -1);

        // Checksum pattern.
        ldq = '{32'hF0F0, 32'h0FF0};
        run_cmd(MODE_LOAD, 5'd1, 5'd2, 0, 0, 0, -1);
        run_cmd(MODE_DUMP, 5'd1, 5'd2, 0, 0, 0, -1);
`ifdef REGDBG_CHECKSUM_EN
        check("csum_ff00", checksum, 32'hFF00);
`endif

        for (int k = 0; k < 25; k++) begin
            m  = 1'($urandom_range(1));
            f  = 5'($urandom_range(31));
            l  = 5'($urandom_range(31));
            sp = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(40));
            run_cmd(m, f, l, int'($urandom_range(3)), sp, 0, -1);
        end

        check("zero_addr_writes", 32'(zero_wr), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
